// File: rtl/shift_sub_pkg.sv
// Shared state encoding and counter sizing for the shift/subtract divider.
package shift_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int N_DEFAULT = 32;
  localparam int CNT_W     = $clog2(N_DEFAULT);

  // Step-counter width for an arbitrary operand width.
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division step: shift remainder left, trial-subtract divisor, keep or restore.
// Combinational, zero latency; no handshake.
module restoring_div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   r_in,
  input  logic [N-1:0] q_in,
  input  logic [N-1:0] d_in,
  output logic [N:0]   r_out,
  output logic [N-1:0] q_out
);

  logic [N:0] r_sh;
  logic [N:0] trial;
  logic       unused_r_msb;

  // The partial remainder is always < divisor, so its top bit is zero on entry.
  assign unused_r_msb = r_in[N];

  always_comb begin
    r_sh  = {r_in[N-1:0], q_in[N-1]};
    trial = r_sh - {1'b0, d_in};
    if (!trial[N]) begin
      r_out = trial;
      q_out = {q_in[N-2:0], 1'b1};
    end else begin
      r_out = r_sh;
      q_out = {q_in[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/shift_sub_divide.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Latency: done N+2 cycles after start (2 for divide-by-zero); start always wins and restarts.
module shift_sub_divide
  import shift_sub_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_w(N);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N:0]     r_q, r_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   d_q, d_d;
  logic           dz_q, dz_d;
  logic [N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]   remainder_q, remainder_d;
  logic           div_by_zero_q, div_by_zero_d;
  logic           done_q, done_d;

  logic [N:0]     r_step;
  logic [N-1:0]   q_step;

  restoring_div_step #(.N(N)) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .d_in  (d_q),
    .r_out (r_step),
    .q_out (q_step)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    r_d           = r_q;
    q_d           = q_q;
    d_d           = d_q;
    dz_d          = dz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    done_d        = 1'b0;

    case (state_q)
      RUN: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = FIN;
      end
      FIN: begin
        // For a zero divisor Q still holds the untouched dividend.
        done_d        = 1'b1;
        quotient_d    = dz_q ? {N{1'b1}} : q_q;
        remainder_d   = dz_q ? q_q : r_q[N-1:0];
        div_by_zero_d = dz_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A start in FIN still lets the finishing result (and its flag) publish.
    if (start) begin
      r_d     = '0;
      q_d     = dividend;
      d_d     = divisor;
      cnt_d   = '0;
      dz_d    = (divisor == '0);
      state_d = (divisor == '0) ? FIN : RUN;
      if (state_q != FIN) div_by_zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      r_q           <= '0;
      q_q           <= '0;
      d_q           <= '0;
      dz_q          <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      r_q           <= r_d;
      q_q           <= q_d;
      d_q           <= d_d;
      dz_q          <= dz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      done_q        <= done_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule
